uart_rx_tx_filter: RTL and testbench

//  Buffered, mode-selectable character filter between the uart receiver and transmitter outputs/inputs.

---
 rtl/uart_rx_tx_filter_pkg.sv | 25 ++
 rtl/uart_rx_tx_filter_fifo.sv | 44 ++++
 rtl/uart_rx_tx_filter.sv | 92 +++++++++
 tb/tb_uart_rx_tx_filter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_tx_filter_pkg.sv
// uart_rx_tx_filter_pkg: mode codes, ASCII constants, FSM states and the case transform
package uart_rx_tx_filter_pkg;
    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_LOWER = 2'b10;
    localparam logic [1:0] MODE_SWAP  = 2'b11;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_e;

    function automatic logic [7:0] transform(input logic [7:0] b, input logic [1:0] m);
        logic lc;
        logic uc;
        logic flip;
        lc = b >= ASCII_LC_A && b <= ASCII_LC_Z;
        uc = b >= ASCII_UC_A && b <= ASCII_UC_Z;
        flip = m == MODE_PASS ? 1'b0 : m == MODE_UPPER ? lc : m == MODE_LOWER ? uc : lc | uc;
        return {b[7:6], b[5] ^ flip, b[4:0]};
    endfunction
endpackage

// File: rtl/uart_rx_tx_filter_fifo.sv
// uart_rx_tx_filter_fifo: byte FIFO with first-word-fall-through head and registered level
module uart_rx_tx_filter_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            level  <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/uart_rx_tx_filter.sv
// uart_rx_tx_filter: buffered case-transforming filter from uart receiver to transmitter
module uart_rx_tx_filter
    import uart_rx_tx_filter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CRLF_EXPAND  = 1,
    parameter int CNT_W        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_error,
    input  logic [1:0]                  mode,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  tx_byte,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            overflow_cnt,
    output logic [CNT_W-1:0]            tx_cnt
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e        state;
    state_e        next_state;
    logic [TW-1:0] timer;
    logic          lf_pending;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [7:0]    head;
    logic [7:0]    head_xf;

    assign push     = rx_valid & ~rx_error & ~full;
    assign drop     = rx_valid & ~rx_error & full;
    assign head_xf  = transform(head, mode);
    assign tx_start = state == ISSUE;

    uart_rx_tx_filter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rx_byte),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        next_state = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !lf_pending && !empty && !tx_busy;
                next_state = (lf_pending || pop) ? ISSUE : IDLE;
            end
            ISSUE:     next_state = WAIT_BUSY;
            WAIT_BUSY: next_state = tx_busy ? WAIT_IDLE : timer == TW'(BUSY_TIMEOUT - 1) ? IDLE : WAIT_BUSY;
            WAIT_IDLE: next_state = tx_busy ? WAIT_IDLE : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // A pending LF takes priority over the FIFO so it directly follows its CR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            lf_pending   <= 1'b0;
            tx_byte      <= '0;
            tx_cnt       <= '0;
            overflow_cnt <= '0;
        end else begin
            state  <= next_state;
            timer  <= state == WAIT_BUSY ? timer + 1'b1 : '0;
            tx_cnt <= tx_cnt + CNT_W'(tx_start);
            if (drop && !(&overflow_cnt)) overflow_cnt <= overflow_cnt + 1'b1;
            if (state == IDLE && lf_pending) begin
                tx_byte    <= ASCII_LF;
                lf_pending <= 1'b0;
            end else if (pop) begin
                tx_byte    <= head_xf;
                lf_pending <= CRLF_EXPAND != 0 && head_xf == ASCII_CR;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_tx_filter.sv
// tb_uart_rx_tx_filter: directed and randomized checks against a queue-based reference model
module tb_uart_rx_tx_filter;
    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_error;
    logic [1:0]  mode;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic [15:0] tx_cnt;

    logic        uart_en;
    logic        hold_busy;
    logic        uart_busy;
    logic        busy_d;
    int          frame;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          t_start[$];
    int          cyc = 0;
    int          busy_viol = 0;
    int          rst_viol = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_cnt = 0;

    assign tx_busy = uart_busy | hold_busy;

    uart_rx_tx_filter #(
        .FIFO_DEPTH(16), .CRLF_EXPAND(1), .CNT_W(16), .BUSY_TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_error     (rx_error),
        .mode         (mode),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .tx_cnt       (tx_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start && !rst_n) rst_viol <= rst_viol + 1;
        if (tx_start && rst_n) begin
            got.push_back(tx_byte);
            t_start.push_back(cyc);
            if (busy_d) busy_viol <= busy_viol + 1;
        end
        busy_d <= tx_busy;
    end

    // Simple uart transmitter: busy for `frame` cycles after each start
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start && uart_en) begin
                uart_busy = 1'b1;
                repeat (frame) @(posedge clk);
                #1;
                uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_xf(input logic [7:0] b, input logic [1:0] m);
        bit lc;
        bit uc;
        lc = b >= 8'h61 && b <= 8'h7A;
        uc = b >= 8'h41 && b <= 8'h5A;
        case (m)
            2'd1:    return lc ? b - 8'd32 : b;
            2'd2:    return uc ? b + 8'd32 : b;
            2'd3:    return lc ? b - 8'd32 : uc ? b + 8'd32 : b;
            default: return b;
        endcase
    endfunction

    task automatic expect_byte(input logic [7:0] b, input logic [1:0] m);
        logic [7:0] x;
        x = ref_xf(b, m);
        exp_q.push_back(x);
        if (x == 8'h0D) exp_q.push_back(8'h0A);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_error = err;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic compare_out(input string tag);
        int k;
        k = 0;
        while ((got.size() < exp_q.size() || fifo_level != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drain"}, 32'(k < 3000), 1);
        repeat (frame + 25) @(negedge clk);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        exp_cnt += exp_q.size();
        check({tag, "_tx_cnt"}, tx_cnt, exp_cnt & 16'hFFFF);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] b;
        logic       err;
        int         r;
        int         n0;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        rx_error = 1'b0;
        mode = 2'b00;
        hold_busy = 1'b0;
        uart_en = 1'b1;
        frame = 4;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow_cnt, 0);
        check("rst_tx_cnt", tx_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        mode = 2'b01;
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte = 8'h61;
        @(negedge clk);
        check("lat_n", tx_start, 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("lat_n1", tx_start, 0);
        @(negedge clk);
        check("lat_n2", tx_start, 1);
        check("lat_byte", tx_byte, 8'h41);
        exp_q.push_back(8'h41);
        compare_out("lat");

        mode = 2'b11;
        send(8'h61, 1'b0);
        send(8'h42, 1'b0);
        send(8'h35, 1'b0);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h35);
        compare_out("swap");

        mode = 2'b00;
        send(8'h0D, 1'b0);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        compare_out("crlf");
        send(8'h0D, 1'b1);
        compare_out("crlf_err");

        for (int batch = 0; batch < 4; batch++) begin
            m = 2'($urandom_range(0, 3));
            mode = m;
            for (int i = 0; i < 10; i++) begin
                r = $urandom_range(0, 3);
                b = r == 0 ? 8'h0D : r == 1 ? 8'(8'h61 + $urandom_range(0, 25)) :
                    r == 2 ? 8'(8'h41 + $urandom_range(0, 25)) : 8'($urandom_range(0, 255));
                err = $urandom_range(0, 7) == 0;
                send(b, err);
                if (!err) expect_byte(b, m);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            compare_out($sformatf("rand%0d", batch));
        end
        check("busy_handshake", busy_viol, 0);

        mode = 2'b10;
        hold_busy = 1'b1;
        for (int i = 0; i < 19; i++) begin
            b = 8'(8'h41 + $urandom_range(0, 25));
            send(b, 1'b0);
            if (i < 16) expect_byte(b, 2'b10);
        end
        @(negedge clk);
        check("ovf_level", fifo_level, 16);
        check("ovf_cnt", overflow_cnt, 3);
        check("ovf_held", got.size(), 0);
        hold_busy = 1'b0;
        compare_out("ovf");

        uart_en = 1'b0;
        mode = 2'b00;
        t_start.delete();
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h79);
        compare_out("timeout");
        check("timeout_gap", 32'(t_start.size() >= 2 && t_start[1] - t_start[0] >= 16 &&
              t_start[1] - t_start[0] <= 18), 1);
        uart_en = 1'b1;

        frame = 30;
        for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 1'b0);
        repeat (4) @(negedge clk);
        check("midrst_level_before", fifo_level, 4);
        check("midrst_sent_before", got.size(), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_level", fifo_level, 0);
        check("midrst_tx_cnt", tx_cnt, 0);
        check("midrst_overflow", overflow_cnt, 0);
        check("midrst_tx_start", tx_start, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = got.size();
        repeat (60) @(negedge clk);
        check("midrst_no_tx", got.size(), n0);
        check("midrst_tx_cnt_after", tx_cnt, 0);
        check("rst_no_start", rst_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
